rca_pipe: RTL and testbench
===========================

RCA_PIPE -- requirements
Module: rca_pipe

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits; WIDTH >= 2.
REQ-002 Parameter STAGES, default 4: number of pipeline stages; 1 <= STAGES <= WIDTH, WIDTH % STAGES == 0; illegal combinations SHALL stop elaboration.
REQ-003 Port clk  input  1: single clock; all state SHALL update on the rising edge.
REQ-004 Port rst_n  input  1: asynchronous, active-low reset.
REQ-005 Port in_valid  input  1: operand set on a, b, cin and sub is valid this cycle.
REQ-006 Port in_ready  output  1: block accepts an operand set this cycle.
REQ-007 Port a  input  WIDTH: operand A.
REQ-008 Port b  input  WIDTH: operand B.
REQ-009 Port cin  input  1: carry-in for add; borrow-in for subtract.
REQ-010 Port sub  input  1: 0 = add, 1 = subtract.
REQ-011 Port out_valid  output  1: sum, carry and overflow hold a result.
REQ-012 Port out_ready  input  1: downstream accepts the result this cycle.
REQ-013 Port sum  output  WIDTH: result.
REQ-014 Port carry  output  1: carry-out of the MSB slice.
REQ-015 Port overflow  output  1: two's-complement signed overflow.

Function
REQ-016 Operand set SHALL be accepted on a rising edge where in_valid && in_ready; this is a transfer.
REQ-017 Result SHALL be consumed on a rising edge where out_valid && out_ready.
REQ-018 Effective operand: b_eff = sub ? ~b : b; c_eff = sub ? ~cin : cin; result = a + b_eff + c_eff, truncated to WIDTH bits, carry = bit WIDTH.
REQ-019 Subtract SHALL yield a - b - cin; carry = 1 means no borrow, 0 means borrow.
REQ-020 overflow SHALL be (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
REQ-021 Datapath SHALL be split into STAGES ripple slices of WIDTH/STAGES bits, LSB slice first; each stage registers its slice sum, its carry, and the not-yet-added upper bits of a and b_eff.
REQ-022 Inter-slice carry SHALL pass only through the stage register, never combinationally across stages.
REQ-023 Each stage SHALL hold a valid bit; stage k advances to k+1 only on a global advance enable.
REQ-024 Advance enable = !out_valid || out_ready; in_ready SHALL equal advance enable.
REQ-025 With no stall, latency SHALL be exactly STAGES cycles from the accepting edge to out_valid high.
REQ-026 Throughput SHALL be one result per cycle while out_ready stays high.
REQ-027 While out_valid && !out_ready, all stage registers, valid bits and outputs SHALL hold unchanged; no result is dropped or duplicated.
REQ-028 Empty slots (valid = 0) SHALL propagate as bubbles; results leave in acceptance order.
REQ-029 sum, carry and overflow SHALL be registered outputs, stable while out_valid is high and unconsumed.
REQ-030 Simultaneous consume and accept in one cycle SHALL be supported with no bubble inserted.
REQ-031 STAGES == WIDTH (1-bit slices) and STAGES == 1 (single registered ripple adder) SHALL both be legal and meet REQ-025.

Reset
REQ-032 rst_n low SHALL immediately clear all stage valid bits, out_valid, sum, carry and overflow to 0, independent of clk.
REQ-033 During reset in_ready SHALL read 1, following REQ-024; transfers are ignored while rst_n is low.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight results; the first accept after release SHALL produce the first out_valid.
REQ-035 Datapath registers other than outputs need no reset; their contents SHALL be unobservable while the owning valid bit is 0.

Verification (WIDTH=16, STAGES=4)
REQ-036 Add wrap: a=0xFFFF, b=0x0001, cin=0, sub=0 -> 4 cycles later sum=0x0000, carry=1, overflow=0.
REQ-037 Signed overflow: a=0x7FFF, b=0x0001, cin=0, sub=0 -> sum=0x8000, carry=0, overflow=1; and a=0x8000, b=0x0001, cin=0, sub=1 -> sum=0x7FFF, carry=1, overflow=1.
REQ-038 Borrow: a=0x0000, b=0x0001, cin=0, sub=1 -> sum=0xFFFF, carry=0, overflow=0; same operands with cin=1 -> sum=0xFFFE.
REQ-039 Backpressure: stream 8 random operand sets back-to-back with out_ready toggling 1,0,0,1,... -> all 8 results match the reference model, in order, each exactly once, and outputs hold while stalled.
REQ-040 Reset mid-flight: accept 3 sets, pull rst_n low for 1 cycle -> out_valid=0 immediately, none of the 3 results appear; a new set then returns after 4 cycles.
REQ-041 Parameter sweep: WIDTH/STAGES = 8/1, 8/8, 32/4 with 1000 random add/sub sets each -> bit-exact against the model, latency = STAGES.

Source files
------------

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor: STAGES slices of WIDTH/STAGES bits, LSB first.
// Inter-slice carries travel only through stage registers; one global advance enable stalls all stages.
module rca_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);
    localparam int SL = WIDTH / STAGES;
    // At least one intermediate slot so the arrays stay legal when STAGES == 1.
    localparam int NM = (STAGES > 1) ? STAGES - 1 : 1;

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_param
        $error("rca_pipe: illegal WIDTH/STAGES combination");
    end

    logic [WIDTH-1:0] mid_a_q [NM];
    logic [WIDTH-1:0] mid_a_d [NM];
    logic [WIDTH-1:0] mid_b_q [NM];
    logic [WIDTH-1:0] mid_b_d [NM];
    logic [WIDTH-1:0] mid_s_q [NM];
    logic [WIDTH-1:0] mid_s_d [NM];
    logic             mid_c_q [NM];
    logic             mid_c_d [NM];
    logic             mid_v_q [NM];
    logic             mid_v_d [NM];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic             adv;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;

    always_comb begin
        logic [WIDTH-1:0] op_a;
        logic [WIDTH-1:0] op_b;
        logic [WIDTH-1:0] op_s;
        logic             op_c;
        logic             op_v;
        logic [SL:0]      slice;

        for (int k = 0; k < NM; k++) begin
            mid_a_d[k] = mid_a_q[k];
            mid_b_d[k] = mid_b_q[k];
            mid_s_d[k] = mid_s_q[k];
            mid_c_d[k] = mid_c_q[k];
            mid_v_d[k] = mid_v_q[k];
        end
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        overflow_d  = overflow_q;

        // Subtract is a + ~b + ~cin, so borrow-in folds into the carry-in.
        op_a  = a;
        op_b  = sub ? ~b : b;
        op_s  = '0;
        op_c  = sub ? ~cin : cin;
        op_v  = in_valid;
        slice = '0;

        for (int k = 0; k < STAGES; k++) begin
            slice = {1'b0, op_a[k*SL +: SL]} + {1'b0, op_b[k*SL +: SL]} + {{SL{1'b0}}, op_c};
            op_s[k*SL +: SL] = slice[SL-1:0];
            if (k < STAGES - 1) begin
                if (adv) begin
                    mid_a_d[k] = op_a;
                    mid_b_d[k] = op_b;
                    mid_s_d[k] = op_s;
                    mid_c_d[k] = slice[SL];
                    mid_v_d[k] = op_v;
                end
                op_a = mid_a_q[k];
                op_b = mid_b_q[k];
                op_s = mid_s_q[k];
                op_c = mid_c_q[k];
                op_v = mid_v_q[k];
            end else if (adv) begin
                out_valid_d = op_v;
                // Bubbles leave the last result on the outputs rather than loading junk.
                if (op_v) begin
                    sum_d      = op_s;
                    carry_d    = slice[SL];
                    overflow_d = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (op_s[WIDTH-1] != op_a[WIDTH-1]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NM; k++) begin
                mid_v_q[k] <= 1'b0;
            end
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            for (int k = 0; k < NM; k++) begin
                mid_v_q[k] <= mid_v_d[k];
            end
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NM; k++) begin
            mid_a_q[k] <= mid_a_d[k];
            mid_b_q[k] <= mid_b_d[k];
            mid_s_q[k] <= mid_s_d[k];
            mid_c_q[k] <= mid_c_d[k];
        end
    end

endmodule

// File: tb/tb_rca_pipe.sv
// Bench for rca_pipe: directed corner cases, backpressure, mid-flight reset and a
// parameter sweep, all scored against an arithmetic reference model.
module tb_rca_pipe;
    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic rst_sw_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   sw_done  = 0;

    always #5 clk = ~clk;

    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, carry, overflow;
    logic [15:0] a, b, sum;

    rca_pipe #(.WIDTH(16), .STAGES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry(carry), .overflow(overflow)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns {overflow, carry, sum[31:0]} from plain signed/unsigned arithmetic.
    function automatic logic [33:0] ref_model(input int w, input longint unsigned x,
                                              input longint unsigned y, input logic ci,
                                              input logic sb);
        longint unsigned mask, tot;
        longint          half, sx, sy, st, c1;
        logic            c, v;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        c1   = ci ? 1 : 0;
        sx   = (longint'(x) >= half) ? longint'(x) - 2 * half : longint'(x);
        sy   = (longint'(y) >= half) ? longint'(y) - 2 * half : longint'(y);
        if (!sb) begin
            tot = x + y + longint'(c1);
            c   = ((tot >> w) & 1) != 0;
            st  = sx + sy + c1;
        end else begin
            tot = x - y - longint'(c1);
            c   = x >= y + longint'(c1);
            st  = sx - sy - c1;
        end
        v = (st < -half) || (st >= half);
        return {v, c, 32'(tot & mask)};
    endfunction

    task automatic one_op(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                          input logic xc, input logic xs, input logic [33:0] exp);
        int lat = 0;
        @(negedge clk);
        a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1; out_ready = 1'b1;
        for (int m = 1; m <= 20 && lat == 0; m++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) lat = m;
        end
        check({tag, "_lat"}, lat, 4);
        check({tag, "_res"}, {overflow, carry, 32'(sum)}, exp);
    endtask

    task automatic stream(input string tag, input int n_ops, input bit rnd);
        logic [33:0] exp_q[$];
        logic [33:0] prev = '0;
        bit          prev_stall = 1'b0;
        bit          rdy, acc = 1'b0;
        int          sent = 0, got = 0;
        for (int n = 0; n < 40 * n_ops + 100 && got < n_ops; n++) begin
            @(negedge clk);
            if (acc) in_valid = 1'b0;
            acc = 1'b0;
            if (prev_stall)
                check({tag, "_hold"}, {out_valid, overflow, carry, 32'(sum)}, {1'b1, prev});
            if (out_valid) begin
                if (exp_q.size() == 0) check({tag, "_spurious"}, out_valid, 1'b0);
                else check({tag, "_res"}, {overflow, carry, 32'(sum)}, exp_q[0]);
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : ((n % 4 == 0) || (n % 4 == 3));
            rdy = !out_valid || out_ready;
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev       = {overflow, carry, 32'(sum)};
            if (!in_valid && sent < n_ops && (!rnd || $urandom_range(0, 2) != 0)) begin
                a = 16'($urandom); b = 16'($urandom);
                cin = 1'($urandom); sub = 1'($urandom);
                in_valid = 1'b1;
            end
            if (in_valid && rdy) begin
                exp_q.push_back(ref_model(16, a, b, cin, sub));
                sent++;
                acc = 1'b1;
            end
            #1;
            check({tag, "_rdy"}, in_ready, rdy);
        end
        check({tag, "_count"}, got, n_ops);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check({tag, "_extra"}, out_valid, 1'b0);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int W = (g == 2) ? 32 : 8;
        localparam int S = (g == 0) ? 1 : (g == 1) ? 8 : 4;
        logic         iv, ir, ci, sb, ov, orr, co, vo;
        logic [W-1:0] xa, xb, xs;

        rca_pipe #(.WIDTH(W), .STAGES(S)) u_sw (
            .clk(clk), .rst_n(rst_sw_n), .in_valid(iv), .in_ready(ir),
            .a(xa), .b(xb), .cin(ci), .sub(sb), .out_valid(ov), .out_ready(orr),
            .sum(xs), .carry(co), .overflow(vo)
        );

        initial begin
            logic [33:0] exp_q[$];
            int          acc_q[$];
            int          seen = 0;
            int          sent = 0;
            iv = 1'b0; orr = 1'b1; xa = '0; xb = '0; ci = 1'b0; sb = 1'b0;
            wait (rst_sw_n === 1'b1);
            for (int n = 0; n < 4000 && seen < 1000; n++) begin
                @(negedge clk);
                check($sformatf("sw%0d_rdy", g), ir, 1'b1);
                if (ov) begin
                    if (exp_q.size() == 0) check($sformatf("sw%0d_spurious", g), ov, 1'b0);
                    else begin
                        check($sformatf("sw%0d_res", g), {vo, co, 32'(xs)}, exp_q.pop_front());
                        check($sformatf("sw%0d_lat", g), n - acc_q.pop_front(), S);
                        seen++;
                    end
                end
                iv = 1'b0;
                if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                    xa = W'($urandom); xb = W'($urandom);
                    ci = 1'($urandom); sb = 1'($urandom);
                    iv = 1'b1;
                    exp_q.push_back(ref_model(W, xa, xb, ci, sb));
                    acc_q.push_back(n);
                    sent++;
                end
            end
            check($sformatf("sw%0d_count", g), seen, 1000);
            sw_done++;
        end
    end

    initial begin
        int lat;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #12;
        check("rst_outputs", {out_valid, overflow, carry, sum}, 19'd0);
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1; rst_sw_n = 1'b1;

        one_op("wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0000});
        one_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000});
        one_op("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF});
        one_op("borrow0", 16'h0000, 16'h0001, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF});
        one_op("borrow1", 16'h0000, 16'h0001, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFE});

        stream("bp", 8, 1'b0);
        stream("rnd", 200, 1'b1);

        // Three sets in flight; reset lands once the oldest is waiting at the output.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 16'h1234 + 16'(i); b = 16'h1111; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        for (int m = 0; m < 10 && lat == 0; m++) begin
            if (out_valid) lat = 1;
            else @(negedge clk);
        end
        check("rst_pre_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        a = 16'h5555; b = 16'h2222; in_valid = 1'b1;
        #1;
        check("rst_async_clear", {out_valid, overflow, carry, sum}, 19'd0);
        check("rst_mid_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rst_flush", out_valid, 1'b0);
        end
        one_op("post_rst", 16'hA5A5, 16'h0F0F, 1'b1, 1'b1, ref_model(16, 16'hA5A5, 16'h0F0F, 1'b1, 1'b1));

        for (int i = 0; i < 10000 && sw_done < 3; i++) @(posedge clk);
        check("sw_done", sw_done, 3);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
